// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides and result flags.
// Optional accumulator feedback for operand B is enabled by defining LOGIC_UNIT_ACC_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 3,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
`ifdef LOGIC_UNIT_ACC_EN
  input  logic             in_use_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_ones
);

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_NAND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XNOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOTA = OP_W'(6);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             s1_load, s2_load;
  logic [WIDTH-1:0] op_b, res;
  logic [CNT_W-1:0] res_ones;
`ifdef LOGIC_UNIT_ACC_EN
  logic             s1_acc_q, s1_acc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  // Handshake: a beat moves on a rising edge when valid && ready; the producer holds its
  // payload while valid && !ready. in_ready depends on out_ready but never on in_valid.
  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    op_b = s1_b_q;
`ifdef LOGIC_UNIT_ACC_EN
    s1_acc_d = s1_load ? in_use_acc : s1_acc_q;
    if (s1_acc_q) op_b = acc_q;
`endif

    case (s1_op_q)
      OP_AND:  res = s1_a_q & op_b;
      OP_OR:   res = s1_a_q | op_b;
      OP_XOR:  res = s1_a_q ^ op_b;
      OP_NAND: res = ~(s1_a_q & op_b);
      OP_NOR:  res = ~(s1_a_q | op_b);
      OP_XNOR: res = ~(s1_a_q ^ op_b);
      OP_NOTA: res = ~s1_a_q;
      default: res = s1_a_q;
    endcase

    res_ones = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      res_ones = res_ones + CNT_W'(res[i]);
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    ones_d     = ones_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = res;
      zero_d     = (res == '0);
      parity_d   = ^res;
      ones_d     = res_ones;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

`ifdef LOGIC_UNIT_ACC_EN
    // Writing at S2 load means the next op entering S2 sees this result as its B.
    acc_d = s2_load ? res : acc_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
      ones_q     <= '0;
`ifdef LOGIC_UNIT_ACC_EN
      s1_acc_q   <= 1'b0;
      acc_q      <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      ones_q     <= ones_d;
`ifdef LOGIC_UNIT_ACC_EN
      s1_acc_q   <= s1_acc_d;
      acc_q      <= acc_d;
`endif
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;
  assign out_ones   = ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed cases plus randomized traffic with backpressure.
module tb_logic_unit_pipe;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef LOGIC_UNIT_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [2:0]    in_op;
  logic          in_use_acc;
  logic          out_zero, out_parity;
  logic [CW-1:0] out_ones;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  m_acc;
  logic [W-1:0]  b_m, e_m, got_e, prev_res;
  logic          prev_stall;
  int            n_checks = 0;
  int            n_err = 0;
  int            cyc = 0;

  logic_unit_pipe #(.WIDTH(W), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef LOGIC_UNIT_ACC_EN
    .in_use_acc(in_use_acc),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_parity(out_parity), .out_ones(out_ones)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: input side pushes the model's result for every accepted beat
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) begin
      b_m = in_b;
      if (ACC_EN && in_use_acc) b_m = m_acc;
      e_m = ref_op(in_a, b_m, in_op);
      m_acc = e_m;
      exp_q.push_back(e_m);
    end
  end

  // scoreboard: output side pops and compares, and checks stall stability
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'b0, out_valid}, 32'd1);
        check("stall_result_held", {24'b0, out_result}, {24'b0, prev_res});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'b0, out_result}, 32'hFFFF_FFFF);
        end else begin
          got_e = exp_q.pop_front();
          check("result", {24'b0, out_result}, {24'b0, got_e});
          check("flags", {out_zero, out_parity, 26'b0, out_ones},
                {(got_e == '0), ^got_e, 26'b0, CW'($countones(got_e))});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    m_acc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic acc);
    logic ok;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_use_acc = ACC_EN ? acc : 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  int c0;
  logic took;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_use_acc = 1'b0; out_ready = 1'b1; m_acc = '0; prev_stall = 1'b0; prev_res = '0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_result", {24'b0, out_result}, 32'd0);
    check("rst_zero", {31'b0, out_zero}, 32'd1);
    check("rst_parity", {31'b0, out_parity}, 32'd0);
    check("rst_ones", {28'b0, out_ones}, 32'd0);
    @(posedge clk); #1;

    // single OR with 2-cycle latency
    send(8'hF0, 8'h3C, 3'd1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    check("or_result", {24'b0, out_result}, 32'h0000_00FC);
    check("or_flags", {out_zero, out_parity, 26'b0, out_ones}, {1'b0, 1'b0, 26'b0, 4'd6});
    @(posedge clk); #1;

    // all opcodes back-to-back: 8 beats must take 8 cycles
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(8'hA5, 8'h0F, 3'(i), 1'b0);
    check("stream_cycles", cyc - c0, 32'd8);
    in_valid = 1'b0;
    drain();

    // backpressure: two accepted, third blocked until out_ready rises
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd2, 1'b0);
    send(8'h56, 8'h78, 3'd1, 1'b0);
    in_valid = 1'b1; in_a = 8'h9A; in_b = 8'hBC; in_op = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h9A, 8'hBC, 3'd0, 1'b0);
    in_valid = 1'b0;
    drain();

    // XOR of equal operands gives the zero result
    send(8'h77, 8'h77, 3'd2, 1'b0);
    in_valid = 1'b0;
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(8'h01, 8'h02, 3'd1, 1'b0);
    send(8'h03, 8'h04, 3'd1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    check("full_in_ready_b", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    m_acc = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_flags", {out_zero, out_parity, 26'b0, out_ones}, {1'b1, 1'b0, 30'b0});
    @(posedge clk); #1;
    out_ready = 1'b1;

    if (ACC_EN) begin
      send(8'h01, 8'h00, 3'd1, 1'b1);
      send(8'h10, 8'h00, 3'd1, 1'b1);
      in_valid = 1'b0;
      drain();
    end

    // randomized traffic with random backpressure
    took = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_op = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) in_b = in_a;
        in_use_acc = ACC_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
